wave_pwm_dac: RTL and testbench
===============================

# wave_pwm_dac

PWM output stage that directly follows the function generator. It accepts the generator's 8-bit sample stream through a valid/ready handshake and buffers it in a small FIFO. Once per PWM period it loads one sample as the duty value and drives a single-bit PWM pin, which an external RC filter turns into an analog waveform. It flags FIFO underrun so firmware and test can detect when the generator is not keeping up.

## Interface
- DATA_W, 8: sample width; PWM period is 2^DATA_W counts.
- FIFO_DEPTH, 4: FIFO entries; power of two, ≥2.
- PRESCALE, 1: clocks per PWM count; ≥1.

- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- s_data  in  DATA_W  sample from the function generator.
- s_valid  in  1  s_data valid.
- s_ready  out  1  FIFO not full; a push occurs when s_valid && s_ready.
- enable  in  1  PWM run enable.
- gain  in  2  amplitude attenuation select; used only with AMPLITUDE_SCALE_EN.
- clr_underrun  in  1  clears the sticky underrun flag.
- pwm_out  out  1  registered PWM output.
- sample_tick  out  1  one-cycle pulse after each load event.
- underrun  out  1  sticky flag; a load event found the FIFO empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current number of FIFO entries.

## Operation
- Counters: pre (0..PRESCALE-1) and cnt (DATA_W bits).
  - When enable=1, pre increments every clock and wraps.
  - cnt increments on the edge where pre==PRESCALE-1, and wraps from 2^DATA_W-1 to 0.
  - When enable=0, pre and cnt are forced to 0 and pwm_out to 0. The FIFO keeps accepting pushes.
- Load event: an edge with enable=1, cnt==0 and pre==0.
  - FIFO non-empty: pop the head into duty (after scaling).
  - FIFO empty: duty holds its previous value and underrun is set.
- pwm_out update: on every enabled edge, pwm_out <= (cnt < duty_in_effect). duty_in_effect is the value being loaded on that same edge, if any.
  - Result: exactly duty×PRESCALE high clocks per period.
  - duty 0 gives pwm_out constant low.
  - duty 2^DATA_W-1 gives pwm_out low for only the last count.
- s_ready = !full (combinational from the FIFO count). No push when full, even if a pop occurs on the same edge.
- Push and pop on the same edge (FIFO not full, not empty): both take effect and fifo_level is unchanged.
- Push onto an empty FIFO during a load event: no bypass. Underrun is set, and the word is stored for the next period.
- underrun: set on an empty load event, cleared by clr_underrun. Set wins when both happen on the same edge.
- Reset values:
  - All FIFO pointers 0, fifo_level 0.
  - duty 0, pre 0, cnt 0.
  - pwm_out 0, sample_tick 0, underrun 0.
  - s_ready 1 (FIFO is empty).
- Reset mid-period: everything returns to the reset values immediately and buffered samples are discarded.

## Timing
- pwm_out has one clock of latency relative to the cnt value it is compared against.
- sample_tick is high for the one cycle after each load edge, whether or not the load succeeded.
- A sample pushed into an empty FIFO appears on pwm_out starting 1 clock after the next load edge.
- A full period spans 2^DATA_W×PRESCALE clocks. Sample throughput is one sample per period.
- Deasserting enable mid-period aborts the period. Re-asserting enable triggers a load event on the first enabled edge.

## Configuration
- AMPLITUDE_SCALE_EN defined: at load time, eff = MID + ((sample − MID) >>> gain), with MID = 2^(DATA_W-1).
  - The arithmetic uses a signed (DATA_W+1)-bit difference; the result always fits in DATA_W bits.
  - gain 0 gives full amplitude; gains 1/2/3 give 1/2, 1/4, 1/8 of the amplitude around midscale.
- AMPLITUDE_SCALE_EN undefined: eff = sample. The gain input is present but ignored.

## Structure
- Package wave_pkg holds:
  - the DATA_W default constant;
  - the MID midscale constant;
  - the gain_t 2-bit typedef.
- Sub-module sample_fifo: synchronous FIFO with push/pop/full/empty/level outputs, parameterised by DATA_W and FIFO_DEPTH, asynchronous reset.
- Top level contains: the counters, the load logic, the optional scaler, the underrun flag and the PWM comparator.

## Test plan
- Reset with rst=1 → pwm_out 0, s_ready 1, fifo_level 0, underrun 0, sample_tick 0.
- PRESCALE=1, push 0x40, enable=1 → exactly 64 high clocks per 256-clock period; first high 1 clock after the load edge; sample_tick pulses once.
- Push 0x00 then 0xFF → period 1 gives 0 high clocks; period 2 gives 255 high clocks then 1 low.
- Push 4 words with enable=0 → s_ready=0 and fifo_level=4; a 5th word with s_valid held is not accepted. Enable → s_ready=1 the cycle after the first load.
- FIFO empty at a load edge → duty held from the previous period and underrun=1. Assert clr_underrun on the next empty load edge → underrun remains 1.
- With AMPLITUDE_SCALE_EN, gain=1 → sample 0xFF gives 191 high clocks; sample 0x00 gives 64. With gain=3, sample 0xFF gives 143.

Source files
------------

// File: rtl/wave_pwm_dac_pkg.sv
// Shared constants and types for the PWM DAC output stage.
// Holds the default sample width, the midscale value and the gain select type.
package wave_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int MID            = 1 << (DEFAULT_DATA_W - 1);

  typedef logic [1:0] gain_t;

endpackage

// File: rtl/wave_pwm_dac_if.sv
// Valid/ready sample stream from the function generator into the PWM DAC.
// The generator drives the master side and the DAC consumes on the slave side.
interface wave_pwm_dac_if
  import wave_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) ();

  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/wave_pwm_dac_sample_fifo.sv
// Small synchronous sample FIFO with level output; depth must be a power of two.
// Pushes while full and pops while empty are ignored.
module sample_fifo
  import wave_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic [DATA_W-1:0]            data_i,
  input  logic                         pop_i,
  output logic [DATA_W-1:0]            data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(FIFO_DEPTH):0]  level_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              doPush;
  logic              doPop;

  assign full_o  = (level_q == LVL_W'(FIFO_DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign data_o  = mem[rdPtr_q];
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;

  // Pointers wrap naturally because the depth is a power of two.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    level_d = level_q;
    if (doPush) wrPtr_d = wrPtr_q + PTR_W'(1);
    if (doPop)  rdPtr_d = rdPtr_q + PTR_W'(1);
    case ({doPush, doPop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/wave_pwm_dac.sv
// PWM output stage: buffers generator samples and loads one duty value per PWM period.
// Optional amplitude scaling around midscale is enabled with `define AMPLITUDE_SCALE_EN.
module wave_pwm_dac
  import wave_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int PRESCALE   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  wave_pwm_dac_if.slave                s,
  input  logic                         enable,
  input  gain_t                        gain,
  input  logic                         clr_underrun,
  output logic                         pwm_out,
  output logic                         sample_tick,
  output logic                         underrun,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

  localparam int               PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] duty_q, duty_d;
  logic              pwm_q, pwm_d;
  logic              tick_q;
  logic              underrun_q, underrun_d;

  logic [DATA_W-1:0] fifoHead;
  logic              fifoFull;
  logic              fifoEmpty;
  logic              pushReq;
  logic              popReq;
  logic              loadEvent;
  logic [DATA_W-1:0] sampleEff;

  sample_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) uFifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (pushReq),
    .data_i  (s.s_data),
    .pop_i   (popReq),
    .data_o  (fifoHead),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .level_o (fifo_level)
  );

  assign s.s_ready = !fifoFull;
  assign pushReq   = s.s_valid && !fifoFull;
  assign loadEvent = enable && (cnt_q == '0) && (pre_q == '0);
  assign popReq    = loadEvent && !fifoEmpty;

`ifdef AMPLITUDE_SCALE_EN
  // Signed excursion from midscale is shifted, then re-centred; the carry never matters.
  localparam logic [DATA_W:0] MID_V = {2'b01, {(DATA_W-1){1'b0}}};
  logic signed [DATA_W:0] sampleDiff;
  logic signed [DATA_W:0] sampleShift;
  logic                   unusedCarry;

  assign sampleDiff  = $signed({1'b0, fifoHead}) - $signed(MID_V);
  assign sampleShift = sampleDiff >>> gain;
  assign {unusedCarry, sampleEff} = MID_V + $unsigned(sampleShift);
`else
  logic unusedGain;

  assign unusedGain = ^gain;
  assign sampleEff  = fifoHead;
`endif

  // Counters, load and comparator; a duty loaded on this edge is compared immediately.
  always_comb begin
    pre_d      = '0;
    cnt_d      = '0;
    duty_d     = duty_q;
    pwm_d      = 1'b0;
    underrun_d = underrun_q;
    if (popReq) duty_d = sampleEff;
    if (enable) begin
      pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PRE_W'(1);
      cnt_d = (pre_q == PRE_LAST) ? cnt_q + DATA_W'(1) : cnt_q;
      pwm_d = (cnt_q < duty_d);
    end
    if (loadEvent && fifoEmpty) underrun_d = 1'b1;
    else if (clr_underrun)      underrun_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q      <= '0;
      cnt_q      <= '0;
      duty_q     <= '0;
      pwm_q      <= 1'b0;
      tick_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      cnt_q      <= cnt_d;
      duty_q     <= duty_d;
      pwm_q      <= pwm_d;
      tick_q     <= loadEvent;
      underrun_q <= underrun_d;
    end
  end

  assign pwm_out     = pwm_q;
  assign sample_tick = tick_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_wave_pwm_dac.sv
// Self-checking bench for wave_pwm_dac: timeline-based reference model plus directed checks.
// Honours `define AMPLITUDE_SCALE_EN for the amplitude scaling expectations.
module tb_wave_pwm_dac;

  localparam int DATA_W   = 8;
  localparam int DEPTH    = 4;
  localparam int PRESCALE = 1;
  localparam int PERIOD   = (1 << DATA_W) * PRESCALE;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [1:0] gain;
  logic       clr_underrun;
  logic       pwm_out;
  logic       sample_tick;
  logic       underrun;
  logic [2:0] fifo_level;

  wave_pwm_dac_if #(.DATA_W(DATA_W)) sIf ();

  wave_pwm_dac #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (DEPTH),
    .PRESCALE   (PRESCALE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s            (sIf),
    .enable       (enable),
    .gain         (gain),
    .clr_underrun (clr_underrun),
    .pwm_out      (pwm_out),
    .sample_tick  (sample_tick),
    .underrun     (underrun),
    .fifo_level   (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int testsRun  = 0;
  int testsFail = 0;

  // Reference model state: FIFO contents, duty and a count of consecutive enabled edges.
  int mQueue[$];
  int mDuty;
  int mEnEdges;
  bit mUnderrun;
  bit mTick;
  bit mPwm;
  bit modelValid = 0;
  int mPos;
  bit mLoad;
  bit mPushOk;

  function automatic int scaleSample(input int smp, input int g);
    int d;
    d = smp - 128;
`ifdef AMPLITUDE_SCALE_EN
    return 128 + (d >>> g);
`else
    return d + 128 + 0 * g;
`endif
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] data);
    sIf.s_valid = 1'b1;
    sIf.s_data  = data;
    @(negedge clk);
    sIf.s_valid = 1'b0;
  endtask

  task automatic measure(input int n, output int highs, output int ticks);
    highs = 0;
    ticks = 0;
    for (int i = 0; i < n; i++) begin
      highs += int'(pwm_out);
      ticks += int'(sample_tick);
      @(negedge clk);
    end
  endtask

  // Model: each enabled edge sits at a position within the period; position 0 is the load.
  always @(posedge clk) begin
    if (rst) begin
      mQueue.delete();
      mDuty     = 0;
      mEnEdges  = 0;
      mUnderrun = 0;
      mTick     = 0;
      mPwm      = 0;
    end else begin
      mPos    = mEnEdges % PERIOD;
      mLoad   = enable && (mPos == 0);
      mPushOk = sIf.s_valid && (mQueue.size() < DEPTH);
      mTick   = mLoad;
      if (mLoad && mQueue.size() == 0) mUnderrun = 1;
      else if (clr_underrun)           mUnderrun = 0;
      if (mLoad && mQueue.size() > 0) mDuty = scaleSample(mQueue.pop_front(), int'(gain));
      if (mPushOk) mQueue.push_back(int'(sIf.s_data));
      mPwm     = enable && ((mPos / PRESCALE) < mDuty);
      mEnEdges = enable ? mEnEdges + 1 : 0;
    end
    modelValid = 1;
  end

  always @(negedge clk) begin
    if (modelValid && !rst) begin
      checkOutput("model pwm_out", int'(pwm_out), int'(mPwm));
      checkOutput("model sample_tick", int'(sample_tick), int'(mTick));
      checkOutput("model underrun", int'(underrun), int'(mUnderrun));
      checkOutput("model fifo_level", int'(fifo_level), mQueue.size());
      checkOutput("model s_ready", int'(sIf.s_ready), int'(mQueue.size() < DEPTH));
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    testsFail++;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
    $fatal(1, "[TB] watchdog expired");
  end

  int hi;
  int tk;

  initial begin
    rst          = 1'b1;
    enable       = 1'b0;
    gain         = 2'b00;
    clr_underrun = 1'b0;
    sIf.s_valid  = 1'b0;
    sIf.s_data   = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset pwm_out", int'(pwm_out), 0);
    checkOutput("reset s_ready", int'(sIf.s_ready), 1);
    checkOutput("reset fifo_level", int'(fifo_level), 0);
    checkOutput("reset underrun", int'(underrun), 0);
    checkOutput("reset sample_tick", int'(sample_tick), 0);
    rst = 1'b0;
    @(negedge clk);

    // Single sample 0x40: 64 high clocks, first high right after the load edge.
    applyStimulus(8'h40);
    checkOutput("t1 level", int'(fifo_level), 1);
    checkOutput("t1 pwm before enable", int'(pwm_out), 0);
    enable = 1'b1;
    @(negedge clk);
    checkOutput("t1 first pwm", int'(pwm_out), 1);
    checkOutput("t1 first tick", int'(sample_tick), 1);
    measure(255, hi, tk);
    checkOutput("t1 high clocks", hi, 64);
    checkOutput("t1 ticks", tk, 1);
    enable = 1'b0;
    @(negedge clk);

    // Extremes: duty 0 then duty 255.
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    checkOutput("t2 level", int'(fifo_level), 2);
    enable = 1'b1;
    @(negedge clk);
    measure(256, hi, tk);
    checkOutput("t2 duty0 highs", hi, 0);
    checkOutput("t2 duty0 ticks", tk, 1);
    measure(255, hi, tk);
    checkOutput("t2 duty255 highs", hi, 255);
    checkOutput("t2 duty255 last count", int'(pwm_out), 0);
    enable = 1'b0;
    @(negedge clk);

    // Fill while disabled, hold a rejected fifth word, then enable.
    applyStimulus(8'h10);
    applyStimulus(8'h20);
    applyStimulus(8'h30);
    applyStimulus(8'h50);
    checkOutput("t3 full s_ready", int'(sIf.s_ready), 0);
    checkOutput("t3 full level", int'(fifo_level), 4);
    sIf.s_valid = 1'b1;
    sIf.s_data  = 8'h99;
    repeat (3) @(negedge clk);
    checkOutput("t3 held level", int'(fifo_level), 4);
    enable = 1'b1;
    @(negedge clk);
    checkOutput("t3 ready after load", int'(sIf.s_ready), 1);
    checkOutput("t3 level after load", int'(fifo_level), 3);
    @(negedge clk);
    checkOutput("t3 refill level", int'(fifo_level), 4);
    sIf.s_valid = 1'b0;

    // Drain four periods, then the empty load holds duty 0x99 and flags underrun.
    repeat (5 * PERIOD - 1) @(negedge clk);
    checkOutput("t4 underrun set", int'(underrun), 1);
    checkOutput("t4 empty tick", int'(sample_tick), 1);
    measure(255, hi, tk);
    checkOutput("t4 held duty highs", hi, 153);
    clr_underrun = 1'b1;
    @(negedge clk);
    clr_underrun = 1'b0;
    checkOutput("t4 set wins over clear", int'(underrun), 1);
    clr_underrun = 1'b1;
    @(negedge clk);
    clr_underrun = 1'b0;
    checkOutput("t4 cleared", int'(underrun), 0);
    enable = 1'b0;
    @(negedge clk);

    // Gain 3 on sample 0xC0: ignored unless scaling is built in.
    gain = 2'b11;
    applyStimulus(8'hC0);
    enable = 1'b1;
    @(negedge clk);
    measure(255, hi, tk);
`ifdef AMPLITUDE_SCALE_EN
    checkOutput("t5 gain3 0xC0 highs", hi, 136);
`else
    checkOutput("t5 gain ignored highs", hi, 192);
`endif
    enable = 1'b0;
    gain   = 2'b00;
    @(negedge clk);

`ifdef AMPLITUDE_SCALE_EN
    gain = 2'b01;
    applyStimulus(8'hFF);
    applyStimulus(8'h00);
    enable = 1'b1;
    @(negedge clk);
    measure(256, hi, tk);
    checkOutput("t6 gain1 0xFF highs", hi, 191);
    measure(255, hi, tk);
    checkOutput("t6 gain1 0x00 highs", hi, 64);
    enable = 1'b0;
    gain   = 2'b11;
    @(negedge clk);
    applyStimulus(8'hFF);
    enable = 1'b1;
    @(negedge clk);
    measure(255, hi, tk);
    checkOutput("t6 gain3 0xFF highs", hi, 143);
    enable = 1'b0;
    gain   = 2'b00;
    @(negedge clk);
`endif

    // Reset mid-period discards buffered samples.
    applyStimulus(8'h80);
    applyStimulus(8'h33);
    applyStimulus(8'h44);
    enable = 1'b1;
    repeat (40) @(negedge clk);
    rst    = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    checkOutput("t7 reset level", int'(fifo_level), 0);
    checkOutput("t7 reset pwm", int'(pwm_out), 0);
    checkOutput("t7 reset s_ready", int'(sIf.s_ready), 1);
    checkOutput("t7 reset tick", int'(sample_tick), 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
    $finish;
  end

endmodule
